// File: rtl/tlb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tlb_pkg
// Brief    : Shared TLB types, op codes and the entry parity function.
// Revision : 1.0
// ============================================================================
package tlb_pkg;

   typedef enum logic [1:0] {
      TLBW_FILL = 2'd0,
      TLBW_INV1 = 2'd1,
      TLBW_INVP = 2'd2,
      TLBW_INVA = 2'd3
   } tlbw_op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_PULSE = 2'd2,
      ST_HOLD  = 2'd3
   } tlbw_state_e;

   // d[19:0] carries D[23:4]; odd parity per group, also used by the lookup checker.
   function automatic logic [2:0] tlb_parity(input logic [19:0] d);
      return {~^d[19:16], ~^d[15:8], ~^d[7:0]};
   endfunction

endpackage
`default_nettype wire

// File: rtl/tlb_writer.sv
`default_nettype none
// ============================================================================
// Module   : tlb_writer
// Brief    : Write-side sequencer for the asynchronous TLB RAM array
//            (fill, invalidate single, invalidate half, invalidate all).
// Revision : 1.0
// ============================================================================
module tlb_writer
   import tlb_pkg::*;
#(
   parameter int          ENTRIES  = 256,
   parameter int          HALF     = 128,
   parameter logic [19:0] INV_DATA = 20'h00000
)(
   input  logic        clk,
   input  logic        nRESET,
   input  logic        req,
   input  logic [1:0]  op,
   input  logic [7:0]  req_addr,
   input  logic [19:0] req_data,
   output logic        ack,
   output logic        done,
   output logic        tlbw_busy,
   output logic [7:0]  A,
   output logic [19:0] D,
   output logic [2:0]  Dp,
   output logic        nWE
);

   localparam logic [7:0] c_LAST_ALL  = 8'(ENTRIES - 1);
   localparam logic [7:0] c_LAST_HALF = 8'(HALF - 1);

   tlbw_state_e r_state;
   tlbw_state_e w_state_nxt;
   logic        r_armed;
   logic [7:0]  r_a;
   logic [7:0]  r_last;
   logic [19:0] r_d;
   logic        r_nwe;
   logic        w_accept;
   logic        w_last;

   // r_armed keeps ack low while reset is asserted even if req is already high.
   assign w_accept = (r_state == ST_IDLE) && req && r_armed;
   assign w_last   = (r_a == r_last);

   always_ff @(posedge clk or negedge nRESET) begin
      if (!nRESET) r_state <= ST_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (w_accept) w_state_nxt = ST_SETUP;
         ST_SETUP: w_state_nxt = ST_PULSE;
         ST_PULSE: w_state_nxt = ST_HOLD;
         ST_HOLD:  w_state_nxt = w_last ? ST_IDLE : ST_SETUP;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      ack       = w_accept;
      done      = (r_state == ST_HOLD) && w_last;
      tlbw_busy = (r_state != ST_IDLE) || w_accept;
   end

   // nWE is registered so the asynchronous RAM never sees a decode glitch.
   always_ff @(posedge clk or negedge nRESET) begin
      if (!nRESET) begin
         r_armed <= 1'b0;
         r_nwe   <= 1'b1;
         r_a     <= 8'h00;
         r_d     <= 20'h00000;
         r_last  <= 8'h00;
      end else begin
         r_armed <= 1'b1;
         r_nwe   <= (w_state_nxt != ST_PULSE);
         if (w_accept) begin
            case (op)
               TLBW_FILL: begin
                  r_a    <= req_addr;
                  r_last <= req_addr;
                  r_d    <= req_data;
               end
               TLBW_INV1: begin
                  r_a    <= req_addr;
                  r_last <= req_addr;
                  r_d    <= INV_DATA;
               end
               TLBW_INVP: begin
                  r_a    <= 8'h00;
                  r_last <= c_LAST_HALF;
                  r_d    <= INV_DATA;
               end
               default: begin
                  r_a    <= 8'h00;
                  r_last <= c_LAST_ALL;
                  r_d    <= INV_DATA;
               end
            endcase
         end else if ((r_state == ST_HOLD) && !w_last) begin
            r_a <= r_a + 8'd1;
         end
      end
   end

   assign A   = r_a;
   assign D   = r_d;
   assign Dp  = tlb_parity(r_d);
   assign nWE = r_nwe;

endmodule
`default_nettype wire
